// File: rtl/demux7_route.sv
// Registered 1-to-7 result router: one valid/ready word is parked in the slot picked by in_sel, visible next cycle, drained by per-slot ack.
// A full, un-acked target slot stalls in_ready. Define DEMUX7_BCAST_EN to make select 7 a broadcast, otherwise select 7 is dropped and flagged.
module demux7_route #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2:0]            in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [7*DATA_W-1:0]   out_data,
  output logic [6:0]            out_valid,
  input  logic [6:0]            out_ack,
  output logic                  err_sel,
  output logic [CNT_W-1:0]      acc_cnt
);

  logic [6:0] slotFree;
  logic [7:0] selFree;
  logic [7:0] selOneHot;
  logic [6:0] wrMask;
  logic       accept;

  // A slot can take a word if it is empty or its consumer drains it this same cycle.
  assign slotFree = ~out_valid | out_ack;

`ifdef DEMUX7_BCAST_EN
  assign selFree = {&slotFree, slotFree};
`else
  assign selFree = {1'b1, slotFree};
`endif

  assign in_ready = selFree[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    selOneHot = 8'b1 << in_sel;
    wrMask    = accept ? selOneHot[6:0] : 7'b0;
`ifdef DEMUX7_BCAST_EN
    if (accept && selOneHot[7]) wrMask = 7'h7F;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 7'b0;
      acc_cnt   <= '0;
    end else begin
      // Write wins over ack, so a same-cycle ack plus write leaves the slot full.
      out_valid <= (out_valid & ~out_ack) | wrMask;
      for (int k = 0; k < 7; k++) begin
        if (wrMask[k]) out_data[k*DATA_W +: DATA_W] <= in_data;
      end
      if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

`ifdef DEMUX7_BCAST_EN
  assign err_sel = 1'b0;
`else
  logic dropWord;
  assign dropWord = accept & selOneHot[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_sel <= 1'b0;
    else if (dropWord) err_sel <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_demux7_route.sv
// Directed, table-driven bench for demux7_route (counter narrowed to 4 bits to reach the wrap).
module tb_demux7_route;

  localparam int DW = 32;
  localparam int CW = 4;
`ifdef DEMUX7_BCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [2:0]      in_sel;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [7*DW-1:0] out_data;
  logic [6:0]      out_valid;
  logic [6:0]      out_ack;
  logic            err_sel;
  logic [CW-1:0]   acc_cnt;

  int nChecks = 0;
  int nErrors = 0;

  demux7_route #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .err_sel(err_sel), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [2:0]  sel;
    logic [31:0] dat;
    logic [6:0]  ack;
    logic        expRdy;
    logic [6:0]  expVld;
    logic [3:0]  expCnt;
    logic        expErr;
    int          slot;
    logic [31:0] expSlot;
  } vec_t;

  vec_t vecs[$];

  function automatic void addV(input string nm, input logic v, input int sel, input logic [31:0] dat,
                               input logic [6:0] ack, input logic rdy, input logic [6:0] vld,
                               input int cnt, input logic err, input int slot, input logic [31:0] sd);
    vec_t t;
    t.name = nm; t.v = v; t.sel = 3'(sel); t.dat = dat; t.ack = ack;
    t.expRdy = rdy; t.expVld = vld; t.expCnt = 4'(cnt); t.expErr = err;
    t.slot = slot; t.expSlot = sd;
    vecs.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [7*DW-1:0] act, input logic [7*DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic applyVec(input vec_t t);
    @(negedge clk);
    in_valid = t.v; in_sel = t.sel; in_data = t.dat; out_ack = t.ack;
    #1;
    check({t.name, " in_ready"}, in_ready, t.expRdy);
    @(posedge clk);
    #1;
    check({t.name, " out_valid"}, out_valid, t.expVld);
    check({t.name, " acc_cnt"}, acc_cnt, t.expCnt);
    check({t.name, " err_sel"}, err_sel, t.expErr);
    check({t.name, " slot"}, out_data[t.slot*DW +: DW], t.expSlot);
  endtask

  initial begin
    vec_t h;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ack = 7'b0;

    // name, v, sel, dat, ack, rdy, vld, cnt, err, slot, slotData
    addV("single",   1, 2, 32'hDEADBEEF, 7'h00, 1, 7'h04, 1, 0, 2, 32'hDEADBEEF);
    addV("ack2",     0, 2, 32'h0,        7'h04, 1, 7'h00, 1, 0, 2, 32'hDEADBEEF);
    addV("bpFill",   1, 5, 32'h1,        7'h00, 1, 7'h20, 2, 0, 5, 32'h1);
    addV("bpStall",  1, 5, 32'h2,        7'h00, 0, 7'h20, 2, 0, 5, 32'h1);
    addV("bpAckWr",  1, 5, 32'h2,        7'h20, 1, 7'h20, 3, 0, 5, 32'h2);
    addV("bpDrain",  0, 5, 32'h0,        7'h20, 1, 7'h00, 3, 0, 5, 32'h2);
    for (int k = 0; k < 7; k++)
      addV("indep", 1, k, 32'(100 + k), 7'h00, 1, 7'((1 << (k + 1)) - 1), 4 + k, 0, k, 32'(100 + k));
    addV("ack036",   0, 0, 32'h0,        7'h49, 1, 7'h36, 10, 0, 3, 32'd103);
    addV("full1",    0, 1, 32'h0,        7'h00, 0, 7'h36, 10, 0, 1, 32'd101);
    addV("ackEmpty", 0, 0, 32'h0,        7'h49, 1, 7'h36, 10, 0, 0, 32'd100);
    addV("sel7Busy", 1, 7, 32'hCAFE,     7'h00, !BC, 7'h36, BC ? 10 : 11, !BC, 1, 32'd101);
    addV("drainAll", 0, 7, 32'h0,        7'h36, 1, 7'h00, BC ? 10 : 11, !BC, 4, 32'd104);
    addV("sel7Idle", 1, 7, 32'hCAFE,     7'h00, 1, BC ? 7'h7F : 7'h00, BC ? 11 : 12, !BC, 4,
         BC ? 32'hCAFE : 32'd104);
    addV("drain7",   0, 7, 32'h0,        7'h7F, 1, 7'h00, BC ? 11 : 12, !BC, 6,
         BC ? 32'hCAFE : 32'd106);

    @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 7'h00);
    check("reset out_data", out_data, '0);
    check("reset err_sel", err_sel, 1'b0);
    check("reset acc_cnt", acc_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) applyVec(vecs[i]);

    // Asynchronous reset with slots 1 and 3 full, asserted between edges.
    h.name = "fill1"; h.v = 1; h.sel = 3'd1; h.dat = 32'd11; h.ack = 7'h00; h.expRdy = 1;
    h.expVld = 7'h02; h.expCnt = BC ? 4'd12 : 4'd13; h.expErr = !BC; h.slot = 1; h.expSlot = 32'd11;
    applyVec(h);
    h.name = "fill3"; h.sel = 3'd3; h.dat = 32'd33; h.expVld = 7'h0A;
    h.expCnt = BC ? 4'd13 : 4'd14; h.slot = 3; h.expSlot = 32'd33;
    applyVec(h);
    in_sel = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", out_valid, 7'h00);
    check("arst out_data", out_data, '0);
    check("arst err_sel", err_sel, 1'b0);
    check("arst acc_cnt", acc_cnt, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("inReset acc_cnt", acc_cnt, 4'd0);
    check("inReset out_valid", out_valid, 7'h00);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // 17 words through slot 0 with a same-cycle ack: counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      h.name = "wrap"; h.v = 1; h.sel = 3'd0; h.dat = 32'(i); h.ack = 7'h01; h.expRdy = 1;
      h.expVld = 7'h01; h.expCnt = 4'((i + 1) % 16); h.expErr = 0; h.slot = 0; h.expSlot = 32'(i);
      applyVec(h);
    end
    h.name = "wrapDrain"; h.v = 0; h.expVld = 7'h00; h.expCnt = 4'd1; h.expSlot = 32'd16;
    applyVec(h);
    h.name = "ackIdle"; h.ack = 7'h7F;
    applyVec(h);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/demux7_route.md
Name: demux7_route

Overview:
- Registered 1-to-7 result router for the multicycle MIPS datapath. It is the distribution side of the 7-input, 3-bit-select datapath multiplexer.
- Accepts one 32-bit word with a 3-bit destination select through a valid/ready handshake. Parks the word in one of seven holding slots (e.g. PC, A, B, ALUOut, MDR, HI, LO staging).
- Each slot is drained independently by its consumer via a per-slot ack.

Parameters:
- DATA_W, 32, width of each data word and slot
- CNT_W, 16, width of accepted-word counter

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer has a word
- in_sel  input  3  destination slot 0..6; 3'b111 is special (see Behaviour)
- in_data  input  DATA_W  word to route
- in_ready  output  1  word accepted this cycle when in_valid and in_ready are both high
- out_data  output  7*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W]
- out_valid  output  7  slot k holds an unconsumed word
- out_ack  input  7  consumer k takes slot k's word when out_valid[k] is high
- err_sel  output  1  sticky flag: a select-7 word was dropped
- acc_cnt  output  CNT_W  number of accepted words

Behaviour:
- Reset (rst_n low, asynchronous): out_data all 0, out_valid 7'b0, err_sel 0, acc_cnt 0. Reset mid-transfer discards every held word. No acceptance occurs while rst_n is low.
- Slot state per k: EMPTY or FULL.
  - EMPTY->FULL on a write to slot k.
  - FULL->EMPTY on out_ack[k] with no same-cycle write.
  - FULL stays FULL on ack plus same-cycle write, and the data is replaced by the new word.
- in_ready (combinational), for in_sel=k in 0..6: high when out_valid[k]=0 or out_ack[k]=1. in_ready never depends on in_valid.
- Acceptance: on the edge where in_valid and in_ready are both high, out_data[k] <= in_data and out_valid[k] <= 1.
  - Latency 1 cycle: the word is visible the cycle after acceptance.
- Other slots are unaffected by a write to slot k. Their data holds while EMPTY; stale data is not cleared.
- out_ack[k] while out_valid[k]=0 is ignored. Several acks in one cycle are all honoured.
- Backpressure: when the selected slot is FULL and not acked, in_ready=0. The producer must hold in_valid, in_sel and in_data stable until accepted.
- in_sel=3'b111 without the optional feature: in_ready=1, and the word is accepted and discarded.
  - err_sel is set to 1 and stays sticky until reset.
  - No slot changes.
- acc_cnt increments by 1 on every accepted word, including dropped and broadcast words. It wraps from 2^CNT_W-1 to 0.
- in_ready and out_valid have no combinational path from in_data.

Optional Feature:
- Macro: DEMUX7_BCAST_EN.
- When defined, in_sel=3'b111 is a broadcast.
  - in_ready = AND over k of (out_valid[k]=0 or out_ack[k]=1).
  - On acceptance, all seven slots load in_data and all out_valid bits go to 1 one cycle later.
  - err_sel is tied to 0.
- When undefined, select-7 words are dropped and flagged as described under Behaviour.

Test Plan:
1. Reset then single write: release rst_n, in_sel=2, in_data=32'hDEADBEEF, in_valid for 1 cycle. Next cycle: out_valid=7'b0000100, slot 2 = DEADBEEF, acc_cnt=1. out_ack[2]=1 for 1 cycle -> out_valid=0.
2. Backpressure: fill slot 5 with 32'h1. Present in_sel=5, data 32'h2 with no ack -> in_ready=0, slot 5 stays 1. Pulse out_ack[5] -> word 2 accepted that cycle, slot 5=2 next cycle, out_valid[5] stays 1.
3. Independent slots: write 0..6 with data k+100 on 7 back-to-back cycles -> in_ready high every cycle, out_valid=7'h7F, acc_cnt=7. Ack 0,3,6 simultaneously -> out_valid=7'b0110110.
4. Select 7: without DEMUX7_BCAST_EN, send in_sel=7, data 32'hCAFE -> in_ready=1, slots unchanged, err_sel=1 held until reset, acc_cnt+1. With DEMUX7_BCAST_EN and all slots empty -> all slots = CAFE, out_valid=7'h7F, err_sel=0. Same with slot 4 FULL and not acked -> in_ready=0.
5. Reset mid-operation: slots 1 and 3 FULL, assert rst_n low between clock edges -> out_valid, out_data, err_sel and acc_cnt clear immediately, without waiting for an edge.
6. Counter wrap (CNT_W=4): 17 accepted words -> acc_cnt=1. Ack on an empty slot -> no state change.
